// File: rtl/display_driver_if.sv
// Stopwatch-to-display bus: refresh request and BCD digits in, MAX7219 serial link and busy out.
// The master modport is the display_driver side; the slave modport is the stopwatch/host side.
interface display_driver_if;
    logic       upd;
    logic [3:0] ces_0X;
    logic [3:0] ces_X0;
    logic [3:0] sec_0X;
    logic [2:0] sec_X0;
    logic [3:0] min_0X;
    logic [2:0] min_X0;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       busy;

    modport master (
        input  upd, ces_0X, ces_X0, sec_0X, sec_X0, min_0X, min_X0,
        output spi_cs_n, spi_clk, spi_mosi, busy
    );

    modport slave (
        output upd, ces_0X, ces_X0, sec_0X, sec_X0, min_0X, min_X0,
        input  spi_cs_n, spi_clk, spi_mosi, busy
    );
endinterface

// File: rtl/display_driver.sv
// MAX7219 driver: sends a 5-frame INIT sequence after reset, then 6-frame DIGITS sequences on request.
// Optional feature macro BLANK_LEADING_ZERO_EN: a zero tens-of-minutes digit is sent as code-B blank.
module display_driver (
    input logic              clk,
    input logic              res,
    display_driver_if.master bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
    typedef enum logic {MODE_INIT, MODE_DIGITS} mode_t;

    state_t      state;
    mode_t       mode;
    logic [2:0]  frame_idx;
    logic [3:0]  bit_cnt;
    logic        phase;
    logic [15:0] shift_reg;
    logic        pending;
    logic        cs_n_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        busy_q;

    logic [3:0]  snap_ces_0x;
    logic [3:0]  snap_ces_x0;
    logic [3:0]  snap_sec_0x;
    logic [2:0]  snap_sec_x0;
    logic [3:0]  snap_min_0x;
    logic [2:0]  snap_min_x0;

    logic [15:0] frame_word;
    logic [3:0]  min_x0_code;
    logic        last_frame;
    logic        take_snapshot;

    assign bus.spi_cs_n = cs_n_q;
    assign bus.spi_clk  = sclk_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.busy     = busy_q;

`ifdef BLANK_LEADING_ZERO_EN
    assign min_x0_code = (snap_min_x0 == 3'd0) ? 4'hF : {1'b0, snap_min_x0};
`else
    assign min_x0_code = {1'b0, snap_min_x0};
`endif

    assign last_frame = (mode == MODE_INIT) ? (frame_idx == 3'd4) : (frame_idx == 3'd5);

    // A DIGITS sequence starts either from IDLE or chained straight onto the end of INIT.
    assign take_snapshot = pending &&
                           (((state == IDLE) && (mode == MODE_DIGITS)) ||
                            ((state == LATCH) && (mode == MODE_INIT) && last_frame));

    always_comb begin
        frame_word = 16'h0000;
        if (mode == MODE_INIT) begin
            case (frame_idx)
                3'd0:    frame_word = 16'h0F00;
                3'd1:    frame_word = 16'h0C01;
                3'd2:    frame_word = 16'h09FF;
                3'd3:    frame_word = 16'h0A07;
                3'd4:    frame_word = 16'h0B05;
                default: frame_word = 16'h0000;
            endcase
        end else begin
            case (frame_idx)
                3'd0:    frame_word = {8'h01, 4'h0, snap_ces_0x};
                3'd1:    frame_word = {8'h02, 4'h0, snap_ces_x0};
                3'd2:    frame_word = {8'h03, 4'h0, snap_sec_0x};
                3'd3:    frame_word = {8'h04, 4'h0, 1'b0, snap_sec_x0};
                3'd4:    frame_word = {8'h05, 4'h0, snap_min_0x};
                3'd5:    frame_word = {8'h06, 4'h0, min_x0_code};
                default: frame_word = 16'h0000;
            endcase
        end
    end

    // A request arriving on the consuming cycle is absorbed by that start.
    always_ff @(posedge clk) begin
        if (!res) begin
            pending <= 1'b1;
        end else if (take_snapshot) begin
            pending <= 1'b0;
        end else if (bus.upd) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            snap_ces_0x <= 4'd0;
            snap_ces_x0 <= 4'd0;
            snap_sec_0x <= 4'd0;
            snap_sec_x0 <= 3'd0;
            snap_min_0x <= 4'd0;
            snap_min_x0 <= 3'd0;
        end else if (take_snapshot) begin
            snap_ces_0x <= bus.ces_0X;
            snap_ces_x0 <= bus.ces_X0;
            snap_sec_0x <= bus.sec_0X;
            snap_sec_x0 <= bus.sec_X0;
            snap_min_0x <= bus.min_0X;
            snap_min_x0 <= bus.min_X0;
        end
    end

    // Outputs are set on entry to each state so every pin comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!res) begin
            state     <= IDLE;
            mode      <= MODE_INIT;
            frame_idx <= 3'd0;
            bit_cnt   <= 4'd0;
            phase     <= 1'b0;
            shift_reg <= 16'h0000;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((mode == MODE_INIT) || pending) begin
                        state     <= LOAD;
                        frame_idx <= 3'd0;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    shift_reg <= {frame_word[14:0], 1'b0};
                    mosi_q    <= frame_word[15];
                    cs_n_q    <= 1'b0;
                    sclk_q    <= 1'b0;
                    bit_cnt   <= 4'd15;
                    phase     <= 1'b0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (!phase) begin
                        sclk_q <= 1'b1;
                        phase  <= 1'b1;
                    end else if (bit_cnt == 4'd0) begin
                        cs_n_q <= 1'b1;
                        sclk_q <= 1'b0;
                        mosi_q <= 1'b0;
                        state  <= LATCH;
                    end else begin
                        bit_cnt   <= bit_cnt - 4'd1;
                        phase     <= 1'b0;
                        sclk_q    <= 1'b0;
                        mosi_q    <= shift_reg[15];
                        shift_reg <= {shift_reg[14:0], 1'b0};
                    end
                end
                LATCH: begin
                    if (!last_frame) begin
                        frame_idx <= frame_idx + 3'd1;
                        state     <= LOAD;
                    end else if ((mode == MODE_INIT) && pending) begin
                        mode      <= MODE_DIGITS;
                        frame_idx <= 3'd0;
                        state     <= LOAD;
                    end else begin
                        mode      <= MODE_DIGITS;
                        frame_idx <= 3'd0;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_driver.sv
// Self-checking bench for display_driver: decodes the serial link into 16-bit frames and
// compares them with frame lists built from the display protocol rules.
module tb_display_driver;

    logic clk = 1'b0;
    logic res = 1'b0;

    display_driver_if bus();

    display_driver dut (
        .clk (clk),
        .res (res),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mon_frames[$];
    int          busy_runs[$];
    int          busy_len  = 0;
    int          aborted   = 0;
    int          proto_err = 0;
    int          cur_bits  = 0;
    logic [15:0] cur_word  = 16'h0;
    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    logic        prev_busy = 1'b0;

    logic [15:0] exp_q[$];
    logic [3:0]  d[6];

    // Link monitor: one sample per cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (bus.spi_cs_n === 1'b0) begin
            if (prev_cs) begin
                cur_bits = 0;
                cur_word = 16'h0;
            end
            if (bus.spi_clk === 1'b1 && !prev_sclk) begin
                if (bus.spi_mosi !== prev_mosi) proto_err++;
                cur_word = {cur_word[14:0], bus.spi_mosi};
                cur_bits++;
            end
            if (bus.spi_clk === 1'b1 && prev_sclk) proto_err++;
        end else begin
            if (bus.spi_clk !== 1'b0 || bus.spi_mosi !== 1'b0) proto_err++;
            if (!prev_cs) begin
                if (cur_bits == 16) mon_frames.push_back(cur_word);
                else aborted++;
            end
        end
        if (bus.busy === 1'b1) begin
            busy_len++;
        end else if (prev_busy) begin
            busy_runs.push_back(busy_len);
            busy_len = 0;
        end
        prev_cs   = (bus.spi_cs_n !== 1'b0);
        prev_sclk = (bus.spi_clk === 1'b1);
        prev_mosi = bus.spi_mosi;
        prev_busy = (bus.busy === 1'b1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_monitor();
        mon_frames.delete();
        busy_runs.delete();
        exp_q.delete();
        busy_len  = 0;
        aborted   = 0;
        proto_err = 0;
    endtask

    task automatic drive_digits();
        bus.ces_0X = d[0];
        bus.ces_X0 = d[1];
        bus.sec_0X = d[2];
        bus.sec_X0 = d[3][2:0];
        bus.min_0X = d[4];
        bus.min_X0 = d[5][2:0];
    endtask

    task automatic random_digits();
        for (int i = 0; i < 6; i++)
            d[i] = 4'($urandom_range(0, (i == 3 || i == 5) ? 7 : 15));
    endtask

    task automatic add_init();
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0C01);
        exp_q.push_back(16'h09FF);
        exp_q.push_back(16'h0A07);
        exp_q.push_back(16'h0B05);
    endtask

    // Digit frame i goes to register i+1 with the digit in the low nibble.
    task automatic add_digits(input logic [3:0] v[6]);
        logic [3:0] code;
        for (int i = 0; i < 6; i++) begin
            code = v[i];
            if (i == 3 || i == 5) code = {1'b0, v[i][2:0]};
`ifdef BLANK_LEADING_ZERO_EN
            if (i == 5 && code == 4'h0) code = 4'hF;
`endif
            exp_q.push_back({8'(i + 1), 4'h0, code});
        end
    endtask

    task automatic wait_busy(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.busy === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_upd(output bit ok);
        bus.upd = 1'b1;
        step();
        bus.upd = 1'b0;
        wait_busy(1'b1, ok);
    endtask

    task automatic test_reset();
        bit ok;
        random_digits();
        drive_digits();
        bus.upd = 1'b0;
        res = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.spi_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n: got %b want 1", bus.spi_cs_n); end
            checks++; if (bus.spi_clk !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk: got %b want 0", bus.spi_clk); end
            checks++; if (bus.spi_mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi: got %b want 0", bus.spi_mosi); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        end
        res = 1'b1;
        clear_monitor();
        step();
        checks++; if (bus.busy !== 1'b1 || bus.spi_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL release_load: busy=%b cs_n=%b want busy=1 cs_n=1", bus.busy, bus.spi_cs_n); end
        step();
        checks++; if (bus.spi_cs_n !== 1'b0) begin errors++; $display("[TB] FAIL release_cs_fall: got %b want 0", bus.spi_cs_n); end
        wait_busy(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL reset_seq_timeout: busy stuck, want 0"); end
        add_init();
        add_digits(d);
        checks++; if (mon_frames.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL reset_seq_count: got %0d want %0d", mon_frames.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (mon_frames[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL reset_seq_frame%0d: got %h want %h", i, mon_frames[i], exp_q[i]); end
        end
        checks++; if (busy_runs.size() != 1 || busy_runs[0] != 374) begin errors++; $display("[TB] FAIL reset_busy_len: got %0d runs first=%0d want 1 run of 374", busy_runs.size(), (busy_runs.size() > 0) ? busy_runs[0] : -1); end
        checks++; if (proto_err !== 0 || aborted !== 0) begin errors++; $display("[TB] FAIL reset_protocol: got proto=%0d aborted=%0d want 0 0", proto_err, aborted); end
    endtask

    task automatic test_digits(input string name, input bit use_random);
        bit ok;
        step();
        clear_monitor();
        if (use_random) random_digits();
        else begin
            d[0] = 4'd5; d[1] = 4'd9; d[2] = 4'd9; d[3] = 4'd5; d[4] = 4'd3; d[5] = 4'd0;
        end
        drive_digits();
        pulse_upd(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL %s_start: busy stayed 0, want 1", name); end
        wait_busy(1'b0, ok);
        add_digits(d);
        checks++; if (mon_frames.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL %s_count: got %0d want %0d", name, mon_frames.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (mon_frames[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL %s_frame%0d: got %h want %h", name, i, mon_frames[i], exp_q[i]); end
        end
        checks++; if (busy_runs.size() != 1 || busy_runs[0] != 204) begin errors++; $display("[TB] FAIL %s_busy_len: got %0d runs first=%0d want 1 run of 204", name, busy_runs.size(), (busy_runs.size() > 0) ? busy_runs[0] : -1); end
        checks++; if (proto_err !== 0 || aborted !== 0) begin errors++; $display("[TB] FAIL %s_protocol: got proto=%0d aborted=%0d want 0 0", name, proto_err, aborted); end
    endtask

    task automatic test_snapshot();
        bit ok;
        logic [3:0] old_d[6];
        step();
        clear_monitor();
        random_digits();
        drive_digits();
        old_d = d;
        pulse_upd(ok);
        for (int i = 0; i < 6; i++) d[i] = ~d[i];
        drive_digits();
        wait_busy(1'b0, ok);
        add_digits(old_d);
        checks++; if (mon_frames.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL snapshot_count: got %0d want %0d", mon_frames.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (mon_frames[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL snapshot_frame%0d: got %h want %h", i, mon_frames[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [3:0] first_d[6];
        step();
        clear_monitor();
        random_digits();
        drive_digits();
        first_d = d;
        pulse_upd(ok);
        random_digits();
        drive_digits();
        for (int p = 0; p < 3; p++) begin
            repeat (20) step();
            bus.upd = 1'b1;
            step();
            bus.upd = 1'b0;
        end
        wait_busy(1'b0, ok);
        step();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart: busy got %b want 1 one cycle after fall", bus.busy); end
        wait_busy(1'b0, ok);
        repeat (20) step();
        add_digits(first_d);
        add_digits(d);
        checks++; if (mon_frames.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL b2b_count: got %0d want %0d", mon_frames.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (mon_frames[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_frame%0d: got %h want %h", i, mon_frames[i], exp_q[i]); end
        end
        checks++; if (busy_runs.size() != 2) begin errors++; $display("[TB] FAIL b2b_runs: got %0d want 2", busy_runs.size()); end
    endtask

    task automatic test_upd_merge();
        bit ok;
        step();
        clear_monitor();
        random_digits();
        drive_digits();
        bus.upd = 1'b1;
        step();
        step();
        bus.upd = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL merge_start: busy got %b want 1", bus.busy); end
        wait_busy(1'b0, ok);
        repeat (20) step();
        checks++; if (busy_runs.size() != 1 || mon_frames.size() != 6) begin errors++; $display("[TB] FAIL merge_single: got %0d runs %0d frames want 1 run 6 frames", busy_runs.size(), mon_frames.size()); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit hit;
        step();
        clear_monitor();
        d[0] = 4'd5; d[1] = 4'd9; d[2] = 4'd9; d[3] = 4'd5; d[4] = 4'd3; d[5] = 4'd0;
        drive_digits();
        pulse_upd(ok);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (mon_frames.size() == 2 && cur_bits == 7 && bus.spi_cs_n === 1'b0 && bus.spi_clk === 1'b0) hit = 1'b1;
            else step();
        end
        checks++; if (!hit) begin errors++; $display("[TB] FAIL abort_reach_bit8: got no bit-8 window want one"); end
        res = 1'b0;
        step();
        checks++; if (bus.spi_cs_n !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_outputs: cs_n=%b busy=%b want 1 0", bus.spi_cs_n, bus.busy); end
        checks++; if (aborted !== 1) begin errors++; $display("[TB] FAIL abort_partial: got %0d partial frames want 1", aborted); end
        step();
        res = 1'b1;
        clear_monitor();
        step();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_restart: busy got %b want 1", bus.busy); end
        wait_busy(1'b0, ok);
        add_init();
        add_digits(d);
        checks++; if (mon_frames.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL abort_seq_count: got %0d want %0d", mon_frames.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (mon_frames[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL abort_seq_frame%0d: got %h want %h", i, mon_frames[i], exp_q[i]); end
        end
        checks++; if (busy_runs.size() != 1 || busy_runs[0] != 374) begin errors++; $display("[TB] FAIL abort_busy_len: got %0d runs first=%0d want 1 run of 374", busy_runs.size(), (busy_runs.size() > 0) ? busy_runs[0] : -1); end
    endtask

    initial begin
        bus.upd = 1'b0;
        test_reset();
        test_digits("fixed", 1'b0);
        for (int k = 0; k < 6; k++) test_digits("random", 1'b1);
        test_snapshot();
        test_back_to_back();
        test_upd_merge();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
